// File: rtl/gate_exhaustive_checker.sv
`default_nettype none
// ============================================================================
// Module      : gate_exhaustive_checker
// Description : Clocked exhaustive driver/checker for a small combinational
//               gate. Steps stim through every input combination, holds each
//               vector for SETTLE cycles, samples dut_y, and compares it to
//               the EXPECT_TT truth table. Reports per-vector failures, an
//               error count and done/pass status.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_exhaustive_checker #(
  parameter int                  N_IN      = 2,
  parameter int                  SETTLE    = 1,
  parameter logic [2**N_IN-1:0]  EXPECT_TT = 4'b0111
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [N_IN-1:0]      stim,
  input  logic                 dut_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [2**N_IN-1:0]   fail_vec
);

  localparam int              c_nvec     = 2**N_IN;
  localparam logic [N_IN-1:0] c_last_idx = N_IN'(c_nvec - 1);
  localparam logic [3:0]      c_settle   = 4'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [N_IN-1:0]     r_idx;
  logic [N_IN-1:0]     r_stim;
  logic [3:0]          r_cnt;
  logic [N_IN:0]       r_err_count;
  logic [c_nvec-1:0]   r_fail_vec;
  logic                r_done;
  logic                w_busy;
  logic                w_accept;
  logic                w_mismatch;
  logic                w_last;

  // Observed output disagrees with the truth-table bit for the current vector.
  assign w_mismatch = (dut_y != EXPECT_TT[r_idx]);
  assign w_last     = (r_idx == c_last_idx);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_SETTLE;
        end
      end
      S_SETTLE: begin
        w_busy = 1'b1;
        // Counter was loaded with SETTLE on entry; the last settle cycle sees 1.
        if (r_cnt == 4'd1) begin
          w_state_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_SETTLE;
        end
      end
      S_DONE: begin
        // A new start restarts the sweep and clears results on the same edge.
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = S_SETTLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Sweep datapath: vector index, settle counter, stimulus and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_stim      <= '0;
      r_cnt       <= 4'd0;
      r_err_count <= '0;
      r_fail_vec  <= '0;
      r_done      <= 1'b0;
    end else if (w_accept) begin
      r_idx       <= '0;
      r_stim      <= '0;
      r_cnt       <= c_settle;
      r_err_count <= '0;
      r_fail_vec  <= '0;
      r_done      <= 1'b0;
    end else if (r_state == S_SETTLE) begin
      r_cnt <= r_cnt - 4'd1;
    end else if (r_state == S_SAMPLE) begin
      if (w_mismatch) begin
        r_err_count       <= r_err_count + (N_IN+1)'(1);
        r_fail_vec[r_idx] <= 1'b1;
      end
      if (w_last) begin
        r_idx  <= '0;
        r_stim <= '0;
        r_done <= 1'b1;
      end else begin
        // stim only moves here, so the gate gets SETTLE full cycles per vector.
        r_idx  <= r_idx + N_IN'(1);
        r_stim <= r_idx + N_IN'(1);
        r_cnt  <= c_settle;
      end
    end
  end

  assign stim      = r_stim;
  assign busy      = w_busy;
  assign done      = r_done;
  assign pass      = r_done & (r_err_count == '0);
  assign err_count = r_err_count;
  assign fail_vec  = r_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_gate_exhaustive_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_exhaustive_checker
// Description : Directed bench for gate_exhaustive_checker. One instance uses
//               SETTLE=1, a second uses SETTLE=3. A behavioural gate model
//               (NAND, AND, or stuck-at-1) feeds dut_y from stim.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_exhaustive_checker;

  localparam int M_NAND  = 0;
  localparam int M_AND   = 1;
  localparam int M_STUCK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  int         mode1 = M_NAND;
  int         mode3 = M_NAND;

  logic [1:0] stim1, stim3;
  logic       y1, y3;
  logic       busy1, busy3, done1, done3, pass1, pass3;
  logic [2:0] err1, err3;
  logic [3:0] fail1, fail3;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic gate(input int mode, input logic [1:0] s);
    case (mode)
      M_NAND:  return ~(s[1] & s[0]);
      M_AND:   return s[1] & s[0];
      default: return 1'b1;
    endcase
  endfunction

  assign y1 = gate(mode1, stim1);
  assign y3 = gate(mode3, stim3);

  gate_exhaustive_checker #(.N_IN(2), .SETTLE(1), .EXPECT_TT(4'b0111)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .stim(stim1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1)
  );

  gate_exhaustive_checker #(.N_IN(2), .SETTLE(3), .EXPECT_TT(4'b0111)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .stim(stim3), .dut_y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vec(fail3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_result(input int which, input logic [2:0] e_err,
                            input logic [3:0] e_fail, input logic e_pass);
    if (which == 0) begin
      chk("err_count", 32'(err1), 32'(e_err));
      chk("fail_vec",  32'(fail1), 32'(e_fail));
      chk("pass",      32'(pass1), 32'(e_pass));
    end else begin
      chk("err_count3", 32'(err3), 32'(e_err));
      chk("fail_vec3",  32'(fail3), 32'(e_fail));
      chk("pass3",      32'(pass3), 32'(e_pass));
    end
  endtask

  // Pulse start so it is seen at edge E0, then check every edge up to done.
  // If mid_k > 0, start is also held high at edge E(mid_k).
  task automatic sweep(input int which, input int mid_k);
    int s;
    int total;
    logic [1:0] st;
    logic bz, dn, ps;
    logic [2:0] er;
    logic [3:0] fv;
    s     = (which != 0) ? 3 : 1;
    total = 4 * (s + 1);
    @(negedge clk);
    if (which != 0) start3 = 1'b1; else start1 = 1'b1;
    for (int k = 0; k <= total; k++) begin
      @(posedge clk);
      #1;
      start1 = 1'b0;
      start3 = 1'b0;
      st = (which != 0) ? stim3 : stim1;
      bz = (which != 0) ? busy3 : busy1;
      dn = (which != 0) ? done3 : done1;
      ps = (which != 0) ? pass3 : pass1;
      er = (which != 0) ? err3  : err1;
      fv = (which != 0) ? fail3 : fail1;
      if (k == 0) begin
        chk("start_clears_err",  32'(er), 32'd0);
        chk("start_clears_fail", 32'(fv), 32'd0);
        chk("start_clears_pass", 32'(ps), 32'd0);
      end
      if (k < total) begin
        chk("stim_seq", 32'(st), 32'(k / (s + 1)));
        chk("busy_in_sweep", 32'(bz), 32'd1);
        chk("done_in_sweep", 32'(dn), 32'd0);
        chk("pass_in_sweep", 32'(ps), 32'd0);
      end else begin
        chk("stim_done", 32'(st), 32'd0);
        chk("busy_done", 32'(bz), 32'd0);
        chk("done_done", 32'(dn), 32'd1);
      end
      if (mid_k > 0 && k + 1 == mid_k) begin
        if (which != 0) start3 = 1'b1; else start1 = 1'b1;
      end
    end
  endtask

  typedef struct {
    int         mode;
    int         mid_k;
    logic [2:0] exp_err;
    logic [3:0] exp_fail;
    logic       exp_pass;
  } vec_t;

  vec_t vecs [4];

  initial begin
    vecs[0] = '{mode: M_NAND,  mid_k: 0, exp_err: 3'd0, exp_fail: 4'b0000, exp_pass: 1'b1};
    vecs[1] = '{mode: M_AND,   mid_k: 0, exp_err: 3'd4, exp_fail: 4'b1111, exp_pass: 1'b0};
    vecs[2] = '{mode: M_STUCK, mid_k: 0, exp_err: 3'd1, exp_fail: 4'b1000, exp_pass: 1'b0};
    vecs[3] = '{mode: M_NAND,  mid_k: 3, exp_err: 3'd0, exp_fail: 4'b0000, exp_pass: 1'b1};

    // Reset state.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stim",  32'(stim1), 32'd0);
    chk("rst_busy",  32'(busy1), 32'd0);
    chk("rst_done",  32'(done1), 32'd0);
    chk("rst_pass",  32'(pass1), 32'd0);
    chk("rst_err",   32'(err1),  32'd0);
    chk("rst_fail",  32'(fail1), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    chk("rst_done3", 32'(done3), 32'd0);
    rst = 1'b0;

    // Table-driven sweeps on the SETTLE=1 instance.
    for (int i = 0; i < 4; i++) begin
      mode1 = vecs[i].mode;
      sweep(0, vecs[i].mid_k);
      chk_result(0, vecs[i].exp_err, vecs[i].exp_fail, vecs[i].exp_pass);
    end

    // Reset mid-sweep at idx=2 with errors already accumulated.
    mode1 = M_AND;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);            // E0
    #1 start1 = 1'b0;
    repeat (4) @(posedge clk); // E4: SETTLE with idx=2
    #1;
    chk("pre_rst_stim", 32'(stim1), 32'd2);
    chk("pre_rst_err",  32'(err1),  32'd2);
    rst = 1'b1;
    @(posedge clk);            // E5 sees reset
    #1;
    rst = 1'b0;
    chk("midrst_busy", 32'(busy1), 32'd0);
    chk("midrst_stim", 32'(stim1), 32'd0);
    chk("midrst_err",  32'(err1),  32'd0);
    chk("midrst_fail", 32'(fail1), 32'd0);
    chk("midrst_done", 32'(done1), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_idle", 32'(busy1), 32'd0);
    mode1 = M_NAND;
    sweep(0, 0);
    chk_result(0, 3'd0, 4'b0000, 1'b1);

    // start and rst together: reset wins.
    @(negedge clk);
    start1 = 1'b1;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    rst    = 1'b0;
    chk("rst_start_busy", 32'(busy1), 32'd0);
    chk("rst_start_done", 32'(done1), 32'd0);

    // SETTLE=3: clean sweep, a failing sweep, then restart from DONE.
    mode3 = M_NAND;
    sweep(1, 0);
    chk_result(1, 3'd0, 4'b0000, 1'b1);
    mode3 = M_STUCK;
    sweep(1, 0);
    chk_result(1, 3'd1, 4'b1000, 1'b0);
    mode3 = M_NAND;
    sweep(1, 0);
    chk_result(1, 3'd0, 4'b0000, 1'b1);

    // Results stay held in DONE.
    repeat (3) @(posedge clk);
    #1;
    chk("held_done3", 32'(done3), 32'd1);
    chk("held_pass3", 32'(pass3), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
